// File: rtl/mac_post_process_if.sv
// Output stream of mac_post_process: show-ahead FIFO head with valid/ready handshake.
interface mac_post_process_if #(
  parameter int OUT_BW = 8
);
  logic [OUT_BW-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/mac_post_process.sv
// Bias-add, round/shift requantise, optional ReLU (MAC_POST_RELU_EN) and saturate an
// accumulator result, then buffer it in a show-ahead FIFO with sticky length/overflow flags.
module mac_post_process #(
  parameter int BW         = 16,
  parameter int OUT_BW     = 8,
  parameter int ACC_LAT    = 4,
  parameter int NUM_CYC    = 32,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_sum,
  input  logic [BW-1:0]       acc_in,
  input  logic [BW-1:0]       bias,
  mac_post_process_if.master  out_if,
  output logic                len_err,
  output logic                ovf_err
);
  localparam int EW = BW + 2;
  localparam int CW = $clog2(NUM_CYC + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_CYC + 1);
  localparam logic [CW-1:0] CNT_EXP = CW'(NUM_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic signed [EW-1:0] RND =
      (SHIFT > 0) ? (EW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (OUT_BW - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE, RUN} state_t;

  logic [ACC_LAT-1:0]       dly_reg;
  logic [ACC_LAT:0]         dly_next;
  logic                     cap_strb;
  state_t                   state_reg;
  logic [CW-1:0]            cnt_reg;
  logic signed [EW-1:0]     sum_ext;
  logic signed [EW-1:0]     r_calc;
  logic signed [EW-1:0]     r1_reg;
  logic                     v1_reg;
  logic signed [EW-1:0]     r_act;
  logic [OUT_BW-1:0]        sat_next;
  logic [OUT_BW-1:0]        d2_reg;
  logic                     v2_reg;

  logic [OUT_BW-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]              wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]              wr_ptr_next, rd_ptr_next;
  logic                     full, rd_en, wr_en;
  logic [OUT_BW-1:0]        out_data_reg, out_data_next;
  logic                     out_valid_reg, out_valid_next;

  // Strobe delay line aligns cap_strb with the completed prior sum on acc_in.
  assign dly_next = {dly_reg, new_sum};
  assign cap_strb = dly_reg[ACC_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_reg <= '0;
    end else begin
      dly_reg <= dly_next[ACC_LAT-1:0];
    end
  end

  // Stage 1 arithmetic: two guard bits keep the rounding add from overflowing.
  always_comb begin
    sum_ext = $signed({{2{acc_in[BW-1]}}, acc_in}) + $signed({{2{bias[BW-1]}}, bias}) + RND;
    r_calc  = sum_ext >>> SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      v1_reg    <= 1'b0;
      r1_reg    <= '0;
      len_err   <= 1'b0;
    end else begin
      v1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cap_strb) begin
            state_reg <= RUN;
            cnt_reg   <= CNT_ONE;
          end
        end
        RUN: begin
          if (cap_strb) begin
            cnt_reg <= CNT_ONE;
            v1_reg  <= 1'b1;
            r1_reg  <= r_calc;
            if (cnt_reg != CNT_EXP) len_err <= 1'b1;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    r_act = r1_reg;
`ifdef MAC_POST_RELU_EN
    if (r1_reg[EW-1]) r_act = '0;
`endif
    if (r_act > SAT_MAX) begin
      sat_next = SAT_MAX[OUT_BW-1:0];
    end else if (r_act < SAT_MIN) begin
      sat_next = SAT_MIN[OUT_BW-1:0];
    end else begin
      sat_next = r_act[OUT_BW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg <= 1'b0;
      d2_reg <= '0;
    end else begin
      v2_reg <= v1_reg;
      if (v1_reg) d2_reg <= sat_next;
    end
  end

  // FIFO: a full FIFO still accepts a write when the head is read on the same edge.
  always_comb begin
    full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    rd_en       = out_valid_reg && out_if.out_ready;
    wr_en       = v2_reg && (!full || rd_en);
    wr_ptr_next = wr_ptr_reg + (AW + 1)'(wr_en);
    rd_ptr_next = rd_ptr_reg + (AW + 1)'(rd_en);
    out_valid_next = (wr_ptr_next != rd_ptr_next);
    out_data_next  = out_data_reg;
    // Registered head: bypass the write data when it lands in the next head slot.
    if (out_valid_next) begin
      if (wr_en && (rd_ptr_next[AW-1:0] == wr_ptr_reg[AW-1:0])) begin
        out_data_next = d2_reg;
      end else begin
        out_data_next = mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= d2_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      ovf_err       <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      if (v2_reg && full && !rd_en) ovf_err <= 1'b1;
    end
  end

  assign out_if.out_data  = out_data_reg;
  assign out_if.out_valid = out_valid_reg;
endmodule

// File: doc/mac_post_process.md
MAC_POST_PROCESS -- requirements
Module: mac_post_process

Interface
REQ-001 SHALL have parameter BW, default 16: width of the accumulated sum and bias (signed).
REQ-002 SHALL have parameter OUT_BW, default 8: width of the requantised output (signed).
REQ-003 SHALL have parameter ACC_LAT, default 4, min 1: cycles from new_sum to the completed prior sum being present on acc_in.
REQ-004 SHALL have parameter NUM_CYC, default 32: expected cycles between consecutive new_sum pulses.
REQ-005 SHALL have parameter SHIFT, default 4, range 0..BW-1: requantisation right shift.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2: output buffer entries.
REQ-007 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-008 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port new_sum, input, 1: the same strobe that drives the upstream accumulator.
REQ-010 SHALL have port acc_in, input, BW: accumulator output, signed.
REQ-011 SHALL have port bias, input, BW: signed bias; quasi-static, sampled at capture.
REQ-012 SHALL have port out_data, output, OUT_BW: FIFO head, signed.
REQ-013 SHALL have port out_valid, output, 1: FIFO non-empty.
REQ-014 SHALL have port out_ready, input, 1: consumer accept; a transfer occurs when out_valid && out_ready on a rising edge.
REQ-015 SHALL have port len_err, output, 1: sticky flag for wrong new_sum spacing.
REQ-016 SHALL have port ovf_err, output, 1: sticky flag for a result dropped because the FIFO was full.

Function
REQ-017 SHALL delay new_sum through an ACC_LAT-stage shift register; its output is cap_strb.
REQ-018 SHALL implement states IDLE and RUN, plus a cycle counter that saturates at NUM_CYC+1.
REQ-019 In IDLE, cap_strb SHALL move the block to RUN and set counter=1, without capturing (no prior sum exists).
REQ-020 In RUN, the counter SHALL increment each cycle without cap_strb.
REQ-021 In RUN, cap_strb SHALL capture acc_in and bias into stage 1 and reload counter=1.
REQ-022 If the counter != NUM_CYC at a RUN capture, the capture SHALL still occur and len_err SHALL set.
REQ-023 Stage 1 SHALL compute s = acc_in + bias at BW+1 bits signed, then r = (s + 2^(SHIFT-1)) >>> SHIFT (no rounding term when SHIFT=0).
REQ-024 Stage 2 SHALL apply ReLU (see Configuration), then saturate r to the signed OUT_BW range [-2^(OUT_BW-1), 2^(OUT_BW-1)-1].
REQ-025 Latency: with capture at edge T, stage 2 registers at T+1 and writes the FIFO at T+2, so out_valid rises after edge T+2 when the FIFO was empty.
REQ-026 The FIFO SHALL be show-ahead: out_data equals the head entry whenever out_valid=1.
REQ-027 When empty, out_valid SHALL be 0 and out_data SHALL hold its last value.
REQ-028 A write to a full FIFO with no simultaneous read SHALL be dropped and SHALL set ovf_err.
REQ-029 A write to a full FIFO with a simultaneous read SHALL be accepted.
REQ-030 Simultaneous read and write on an empty FIFO: the write SHALL be accepted and out_valid SHALL be 1 the next cycle.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy is tracked with an extra pointer bit.
REQ-032 len_err and ovf_err SHALL clear only on reset.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE, counter 0, strobe delay line 0, pipeline valids 0, FIFO empty, out_data 0, out_valid 0, len_err 0, ovf_err 0.
REQ-034 Reset mid-operation SHALL discard all in-flight results; the first cap_strb after reset is treated as the IDLE opener (REQ-019).

Configuration
REQ-035 Macro MAC_POST_RELU_EN defined: stage 2 SHALL force negative r to 0 before saturation, giving output range [0, 2^(OUT_BW-1)-1].
REQ-036 Macro MAC_POST_RELU_EN undefined: no ReLU; negative results SHALL pass through signed saturation.

Verification (defaults, bias=0 unless stated)
REQ-037 Strobes every 32 cycles, acc_in=256 at the 2nd cap_strb -> out_data=0x10 three edges later; len_err=0.
REQ-038 acc_in=0x7FFF, bias=0x0100 -> (33023+8)>>>4=2064 saturates -> out_data=0x7F.
REQ-039 acc_in=-1000 -> -62: out_data=0x00 with MAC_POST_RELU_EN, 0xC2 without.
REQ-040 Second strobe 31 cycles after the first -> len_err=1 and result still emitted; len_err stays 1.
REQ-041 out_ready=0 and five captured sums -> four entries held, ovf_err=1; out_ready=1 then drains the first four in order.
REQ-042 rst_n low for 1 cycle between strobe and capture -> no output, out_valid=0, flags 0; the next strobe only opens RUN.
